linebuffer_fetch_sched: RTL and testbench

//  Schedules framebuffer-memory traffic around the beam position from display_timings.

---
 rtl/linebuffer_fetch_sched.sv | 168 ++++++++++++++++
 tb/tb_linebuffer_fetch_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/linebuffer_fetch_sched.sv
// Framebuffer port scheduler: one line-buffer burst per active line ahead of
// the beam, host traffic in the gaps, underrun flag on a missed deadline.
module linebuffer_fetch_sched #(
  parameter int LINE_WORDS = 80,
  parameter int V_FIRST    = 45,
  parameter int V_RES      = 480,
  parameter int FETCH_H    = 0,
  parameter int H_LAST     = 799,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 64,
  parameter int LB_AW      = 8
) (
  input  logic              i_pixclk,
  input  logic              i_rst,
  input  logic [15:0]       i_h,
  input  logic [15:0]       i_v,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_lb_we,
  output logic [LB_AW-1:0]  o_lb_addr,
  output logic [DATA_W-1:0] o_lb_data,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic              o_host_ack,
  output logic [DATA_W-1:0] o_host_rdata,
  output logic              o_underrun
);

  localparam int WW  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int LNW = (V_RES > 1) ? $clog2(V_RES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOST,
    DRAIN
  } state_t;

  state_t         state;
  logic           pending;
  logic [LNW-1:0] pend_line;
  logic [LNW-1:0] line;
  logic [WW-1:0]  word;

  logic           trig;
  logic           deadline;
  logic           last_word;
  logic [LNW-1:0] trig_line;
  logic [LNW-1:0] start_line;
  logic [WW-1:0]  word_nx;

  function automatic logic [ADDR_W-1:0] fetch_addr(
    input logic [LNW-1:0] l,
    input logic [WW-1:0]  w
  );
    return ADDR_W'(32'(l) * 32'(LINE_WORDS) + 32'(w));
  endfunction

  function automatic logic [LB_AW-1:0] buf_addr(
    input logic           half,
    input logic [WW-1:0]  w
  );
    return LB_AW'((half ? 32'(LINE_WORDS) : 32'd0) + 32'(w));
  endfunction

  // Trigger window is one line ahead of the active region.
  always_comb begin
    trig = (i_h == 16'(FETCH_H))
        && (32'(i_v) >= 32'(V_FIRST - 1))
        && (32'(i_v) <= 32'(V_FIRST + V_RES - 2));
    trig_line  = LNW'(32'(i_v) - 32'(V_FIRST - 1));
    start_line = trig ? trig_line : pend_line;
    deadline   = (i_h == 16'(H_LAST));
    last_word  = (word == WW'(LINE_WORDS - 1));
    word_nx    = word + WW'(1);
  end

  always_ff @(posedge i_pixclk) begin
    if (i_rst) begin
      state        <= IDLE;
      pending      <= 1'b0;
      pend_line    <= '0;
      line         <= '0;
      word         <= '0;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_lb_we      <= 1'b0;
      o_lb_addr    <= '0;
      o_lb_data    <= '0;
      o_host_ack   <= 1'b0;
      o_host_rdata <= '0;
      o_underrun   <= 1'b0;
    end else begin
      o_lb_we    <= 1'b0;
      o_host_ack <= 1'b0;
      o_underrun <= 1'b0;
      if (trig) begin
        pending   <= 1'b1;
        pend_line <= trig_line;
      end
      unique case (state)
        IDLE: begin
          if (pending || trig) begin
            state      <= FETCH;
            pending    <= 1'b0;
            line       <= start_line;
            word       <= '0;
            o_mem_req  <= 1'b1;
            o_mem_we   <= 1'b0;
            o_mem_addr <= fetch_addr(start_line, '0);
          end else if (i_host_req) begin
            state       <= HOST;
            o_mem_req   <= 1'b1;
            o_mem_we    <= i_host_we;
            o_mem_addr  <= i_host_addr;
            o_mem_wdata <= i_host_wdata;
          end
        end
        FETCH: begin
          if (i_mem_ack) begin
            o_lb_we   <= 1'b1;
            o_lb_addr <= buf_addr(line[0], word);
            o_lb_data <= i_mem_rdata;
            if (last_word) begin
              state     <= IDLE;
              o_mem_req <= 1'b0;
            end else if (deadline) begin
              state      <= IDLE;
              o_mem_req  <= 1'b0;
              o_underrun <= 1'b1;
            end else begin
              word       <= word_nx;
              o_mem_addr <= fetch_addr(line, word_nx);
            end
          end else if (deadline) begin
            // Request already on the bus: wait out its ack, drop the data.
            state      <= DRAIN;
            o_underrun <= 1'b1;
          end
        end
        HOST: begin
          if (i_mem_ack) begin
            state        <= IDLE;
            o_mem_req    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_host_ack   <= 1'b1;
            o_host_rdata <= i_mem_rdata;
          end
        end
        DRAIN: begin
          if (i_mem_ack) begin
            state     <= IDLE;
            o_mem_req <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_linebuffer_fetch_sched.sv
// Randomized bench for linebuffer_fetch_sched: bench-side memory, host
// agent and a transaction-level model of line fetches and deadlines.
module tb_linebuffer_fetch_sched;

  localparam int LW   = 80;
  localparam int VF   = 45;
  localparam int VR   = 480;
  localparam int HL   = 799;
  localparam int HB   = 40000;

  logic        i_pixclk = 1'b0;
  logic        i_rst = 1'b1;
  logic [15:0] i_h = '0;
  logic [15:0] i_v = '0;
  logic        o_mem_req, o_mem_we;
  logic [15:0] o_mem_addr;
  logic [63:0] o_mem_wdata;
  logic        i_mem_ack = 1'b0;
  logic [63:0] i_mem_rdata = '0;
  logic        o_lb_we;
  logic [7:0]  o_lb_addr;
  logic [63:0] o_lb_data;
  logic        i_host_req = 1'b0;
  logic        i_host_we = 1'b0;
  logic [15:0] i_host_addr = '0;
  logic [63:0] i_host_wdata = '0;
  logic        o_host_ack;
  logic [63:0] o_host_rdata;
  logic        o_underrun;

  linebuffer_fetch_sched dut (
    .i_pixclk(i_pixclk), .i_rst(i_rst), .i_h(i_h), .i_v(i_v),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_lb_we(o_lb_we), .o_lb_addr(o_lb_addr), .o_lb_data(o_lb_data),
    .i_host_req(i_host_req), .i_host_we(i_host_we),
    .i_host_addr(i_host_addr), .i_host_wdata(i_host_wdata),
    .o_host_ack(o_host_ack), .o_host_rdata(o_host_rdata),
    .o_underrun(o_underrun)
  );

  always #5 i_pixclk = ~i_pixclk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [63:0] mem [int];

  function automatic logic [63:0] memf(input int a);
    if (mem.exists(a)) return mem[a];
    return {32'(a) * 32'h9E3779B1, 32'hA5000000 | 32'(a)};
  endfunction

  // model state
  bit          f_act, drain;
  int          f_line, f_word, drain_addr;
  bit          h_busy, h_we;
  int          h_addr;
  logic [63:0] h_wd;
  int          ack_pct = 100, ack_every = 0, host_rate = 0;
  int          rst_word = -1;
  int          reads_line, und_cnt, host_mark, host_done, cyc;
  logic        s_req, s_we;
  logic [15:0] s_addr;
  logic [63:0] s_wd;

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, o_mem_req, 0);
    chk({tag, "_we"}, o_mem_we, 0);
    chk({tag, "_addr"}, o_mem_addr, 0);
    chk({tag, "_wdata"}, o_mem_wdata, 0);
    chk({tag, "_lbwe"}, o_lb_we, 0);
    chk({tag, "_lbaddr"}, o_lb_addr, 0);
    chk({tag, "_lbdata"}, o_lb_data, 0);
    chk({tag, "_hack"}, o_host_ack, 0);
    chk({tag, "_hrdata"}, o_host_rdata, 0);
    chk({tag, "_und"}, o_underrun, 0);
  endtask

  task automatic cycle();
    bit          ack, do_rst, e_lb, e_und, e_hack, e_hrd_chk;
    int          a, e_lba;
    logic [63:0] e_lbd, e_hrd;
    do_rst = (rst_word >= 0) && f_act && (f_word == rst_word);
    ack = 1'b0;
    if (!do_rst && s_req)
      ack = (ack_every > 0) ? (cyc % ack_every == 0)
                            : ($urandom_range(99) < ack_pct);
    a = int'(s_addr);
    i_rst = do_rst;
    i_mem_ack = ack;
    i_mem_rdata = ack ? memf(a) : {$urandom, $urandom};
    i_host_req = h_busy;
    i_host_we = h_we;
    i_host_addr = 16'(h_addr);
    i_host_wdata = h_wd;
    e_lb = 0; e_und = 0; e_hack = 0; e_hrd_chk = 0;
    e_lba = 0; e_lbd = '0; e_hrd = '0;
    if (do_rst) begin
      f_act = 0;
      drain = 0;
      rst_word = -1;
    end else begin
      if (ack) begin
        if (a >= HB) begin
          chk("host_addr", a, h_busy ? h_addr : -1);
          chk("host_we", s_we, h_we);
          if (h_we) begin
            chk("host_wdata", s_wd, h_wd);
            mem[a] = h_wd;
          end else begin
            e_hrd_chk = 1;
            e_hrd = i_mem_rdata;
          end
          e_hack = 1;
          host_mark = reads_line;
        end else if (drain) begin
          chk("drain_addr", a, drain_addr);
          chk("drain_we", s_we, 0);
          drain = 0;
        end else if (f_act) begin
          chk("fetch_addr", a, f_line * LW + f_word);
          chk("fetch_we", s_we, 0);
          e_lb = 1;
          e_lba = (f_line % 2) * LW + f_word;
          e_lbd = i_mem_rdata;
          f_word++;
          reads_line++;
          if (f_word == LW) f_act = 0;
        end else begin
          chk("unexpected_mem_req", s_req, 0);
        end
      end
      if (i_h == 16'(HL) && f_act) begin
        e_und = 1;
        f_act = 0;
        und_cnt++;
        if (!ack) begin
          drain = 1;
          drain_addr = f_line * LW + f_word;
        end
      end
      if (i_h == 0 && i_v >= VF - 1 && i_v <= VF + VR - 2) begin
        f_act = 1;
        f_line = int'(i_v) - (VF - 1);
        f_word = 0;
      end
    end
    @(posedge i_pixclk);
    @(negedge i_pixclk);
    cyc++;
    if (do_rst) begin
      chk_zero("midrst");
    end else begin
      chk("lb_we", o_lb_we, e_lb);
      if (e_lb) begin
        chk("lb_addr", o_lb_addr, e_lba);
        chk("lb_data", o_lb_data, e_lbd);
      end
      chk("underrun", o_underrun, e_und);
      chk("host_ack", o_host_ack, e_hack);
      if (e_hrd_chk) chk("host_rdata", o_host_rdata, e_hrd);
      if (e_hack) begin
        h_busy = 0;
        host_done++;
      end
      if (s_req && !ack) begin
        chk("req_held", o_mem_req, 1);
        chk("addr_stable", o_mem_addr, s_addr);
        chk("we_stable", o_mem_we, s_we);
        if (s_we) chk("wdata_stable", o_mem_wdata, s_wd);
      end
    end
    s_req = o_mem_req;
    s_we = o_mem_we;
    s_addr = o_mem_addr;
    s_wd = o_mem_wdata;
  endtask

  task automatic host_start();
    h_busy = 1;
    h_we = $urandom_range(1);
    h_addr = HB + $urandom_range(63);
    h_wd = {$urandom, $urandom};
  endtask

  task automatic run_line(input int v);
    reads_line = 0;
    for (int h = 0; h <= HL; h++) begin
      i_h = 16'(h);
      i_v = 16'(v);
      if (!h_busy && h < 700 && $urandom_range(99) < host_rate)
        host_start();
      cycle();
    end
  endtask

  initial begin
    f_act = 0; drain = 0; h_busy = 0; h_we = 0; h_addr = HB; h_wd = '0;
    und_cnt = 0; host_done = 0; cyc = 0;
    s_req = 0; s_we = 0; s_addr = '0; s_wd = '0;
    i_rst = 1;
    for (int i = 0; i < 3; i++) begin
      i_h = 16'($urandom);
      i_v = 16'(VF);
      i_mem_ack = 1'b1;
      i_host_req = 1'b1;
      i_mem_rdata = {$urandom, $urandom};
      @(posedge i_pixclk);
      @(negedge i_pixclk);
    end
    chk_zero("reset");
    i_rst = 0;
    i_mem_ack = 0;
    i_host_req = 0;
    i_h = 16'(HL);
    i_v = 16'(1000);
    cycle();

    // line 0..1 and last line, full-rate memory
    run_line(44);
    chk("t1_reads", reads_line, LW);
    chk("t1_und", und_cnt, 0);
    run_line(45);
    chk("t2_reads", reads_line, LW);
    run_line(523);
    chk("t2_last_reads", reads_line, LW);

    // host write collides with trigger
    h_busy = 1; h_we = 1; h_addr = HB + 5; h_wd = 64'hDEAD_BEEF_0123_4567;
    host_mark = -1;
    run_line(100);
    chk("t3_fetch_first", host_mark, LW);
    chk("t3_host_done", h_busy, 0);

    // slow memory forces an underrun and a drain
    ack_every = 11;
    run_line(50);
    chk("t4_und", und_cnt, 1);
    ack_every = 0;
    run_line(51);
    chk("t4_recover_reads", reads_line, LW);
    chk("t4_und_once", und_cnt, 1);

    // reset mid-burst, then a fresh line
    rst_word = 30;
    run_line(60);
    chk("t5_reads_at_rst", reads_line, 30);
    run_line(61);
    chk("t5_restart_reads", reads_line, LW);

    // blanking lines with host traffic
    host_rate = 4;
    for (int i = 0; i < 6; i++) begin
      ack_pct = $urandom_range(30, 100);
      run_line((i % 2 == 0) ? $urandom_range(43) : $urandom_range(524, 700));
      chk("t6_blank_reads", reads_line, 0);
    end

    // random active lines, random memory latency
    for (int i = 0; i < 8; i++) begin
      ack_pct = $urandom_range(8, 100);
      run_line($urandom_range(44, 523));
    end
    host_rate = 0;
    ack_pct = 100;
    i_v = 16'(1000);
    for (int i = 0; i < 200; i++) begin
      i_h = 16'(i + 1);
      cycle();
    end
    chk("final_host_idle", h_busy, 0);
    chk("final_no_drain", drain, 0);
    chk("host_ops_seen", host_done > 3, 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
